// File: rtl/video_dnn_pkg.sv
// Shared definitions for the video DNN front-end blocks.
//   ST_*    : frame scheduler state encodings (2-bit, legacy-compatible)
//   SOF_BIT : tuser bit carrying start-of-frame
package video_dnn_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_PASS     = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  localparam int SOF_BIT = 0;

endpackage

// File: rtl/video_dnn_frame_scheduler_if.sv
// AXI4-Stream beat bundle used on both sides of the frame scheduler.
//   tuser/tlast/tdata/tvalid : driven by the master
//   tready                   : driven by the slave
interface video_dnn_frame_scheduler_if #(
  parameter int TUSER_WIDTH = 1,
  parameter int TDATA_WIDTH = 8
) ();

  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tlast;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (
    output tuser, tlast, tdata, tvalid,
    input  tready
  );

  modport slave (
    input  tuser, tlast, tdata, tvalid,
    output tready
  );

endinterface

// File: rtl/video_dnn_blank_generator.sv
// Flush-line generator: after a start pulse, produces width x lines beats
// through a valid/ready interface; beat_last marks the end of each line and
// done pulses when the final beat is taken.
//   aclk, aresetn : clock, async active-low reset
//   start         : begin a new flush run (counters restart at 0)
//   width, lines  : beats per line, number of lines (must be stable while active)
//   beat_valid    : a flush beat is available
//   beat_last     : current beat is the last of its line
//   beat_ready    : consumer takes the beat this cycle
//   done          : final beat of the run taken this cycle
module video_dnn_blank_generator
  import video_dnn_pkg::*;
#(
  parameter int IMG_X_WIDTH   = 10,
  parameter int BLANK_Y_WIDTH = 8
) (
  input  logic                     aresetn,
  input  logic                     aclk,
  input  logic                     start,
  input  logic [IMG_X_WIDTH-1:0]   width,
  input  logic [BLANK_Y_WIDTH-1:0] lines,
  output logic                     beat_valid,
  output logic                     beat_last,
  input  logic                     beat_ready,
  output logic                     done
);

  localparam logic [IMG_X_WIDTH-1:0]   X_ONE = 1;
  localparam logic [BLANK_Y_WIDTH-1:0] Y_ONE = 1;

  logic                     active;
  logic [IMG_X_WIDTH-1:0]   x_cnt;
  logic [BLANK_Y_WIDTH-1:0] y_cnt;
  logic                     x_end;
  logic                     y_end;

  assign x_end      = (x_cnt == width - X_ONE);
  assign y_end      = (y_cnt == lines - Y_ONE);
  assign beat_valid = active;
  assign beat_last  = active && x_end;
  assign done       = active && beat_ready && x_end && y_end;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      active <= 1'b0;
      x_cnt  <= '0;
      y_cnt  <= '0;
    end else if (start) begin
      active <= 1'b1;
      x_cnt  <= '0;
      y_cnt  <= '0;
    end else if (active && beat_ready) begin
      if (x_end) begin
        x_cnt <= '0;
        if (y_end) begin
          active <= 1'b0;
        end else begin
          y_cnt <= y_cnt + Y_ONE;
        end
      end else begin
        x_cnt <= x_cnt + X_ONE;
      end
    end
  end

endmodule

// File: rtl/video_dnn_frame_scheduler.sv
// Frame-level sequencer in front of the binarizer/DNN pipeline. Admits whole
// frames only (optionally decimated by param_skip), appends param_blank_num
// zero lines after each admitted frame to flush line-buffered stages, and
// discards input while idle or skipping so the source never stalls.
//   aresetn, aclk        : async active-low reset, clock
//   ctl_enable           : run request, acted on at frame boundaries
//   param_*              : frame geometry / flush / decimation, latched at admitted SOF
//   s_axi4s (slave)      : input video stream
//   m_axi4s (master)     : stream towards the binarizer, one register stage
//   status_busy          : high while a frame or its flush is in progress
//   status_frame_count   : admitted-and-completed frames (wraps)
//   status_error_count   : premature SOF events (saturates)
module video_dnn_frame_scheduler
  import video_dnn_pkg::*;
#(
  parameter int TUSER_WIDTH   = 1,
  parameter int TDATA_WIDTH   = 8,
  parameter int IMG_X_WIDTH   = 10,
  parameter int IMG_Y_WIDTH   = 10,
  parameter int BLANK_Y_WIDTH = 8,
  parameter int SKIP_WIDTH    = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     aresetn,
  input  logic                     aclk,
  input  logic                     ctl_enable,
  input  logic [IMG_X_WIDTH-1:0]   param_width,
  input  logic [IMG_Y_WIDTH-1:0]   param_height,
  input  logic [BLANK_Y_WIDTH-1:0] param_blank_num,
  input  logic [SKIP_WIDTH-1:0]    param_skip,
  video_dnn_frame_scheduler_if.slave  s_axi4s,
  video_dnn_frame_scheduler_if.master m_axi4s,
  output logic                     status_busy,
  output logic [COUNT_WIDTH-1:0]   status_frame_count,
  output logic [COUNT_WIDTH-1:0]   status_error_count
);

  localparam logic [IMG_Y_WIDTH-1:0] Y_ONE   = 1;
  localparam logic [SKIP_WIDTH-1:0]  S_ONE   = 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [1:0]               state;
  logic [SKIP_WIDTH-1:0]    skip_cnt;
  logic [IMG_Y_WIDTH-1:0]   y_cnt;
  logic [IMG_X_WIDTH-1:0]   width_l;
  logic [IMG_Y_WIDTH-1:0]   height_l;
  logic [BLANK_Y_WIDTH-1:0] blank_l;

  logic [TUSER_WIDTH-1:0]   out_tuser_p1;
  logic                     out_tlast_p1;
  logic [TDATA_WIDTH-1:0]   out_tdata_p1;
  logic                     out_tvalid_p1;

  logic                     out_load;
  logic                     s_ready;
  logic                     s_hs;
  logic                     s_sof;
  logic                     admit;
  logic                     in_frame;
  logic                     frame_end;
  logic [IMG_Y_WIDTH-1:0]   y_base;
  logic [IMG_Y_WIDTH-1:0]   height_cur;
  logic [BLANK_Y_WIDTH-1:0] blank_cur;
  logic                     bg_start;
  logic                     bg_ready;
  logic                     bg_valid;
  logic                     bg_last;
  logic                     bg_done;

  assign out_load = !out_tvalid_p1 || m_axi4s.tready;

  // WAIT_SOF only holds off the source when the beat could be an admitted SOF
  // and the output register is still occupied; otherwise input never stalls.
  always_comb begin
    s_ready = 1'b0;
    case (state)
      ST_IDLE:     s_ready = 1'b1;
      ST_WAIT_SOF: s_ready = out_load || (skip_cnt != '0);
      ST_PASS:     s_ready = out_load;
      default:     s_ready = 1'b0;
    endcase
  end

  assign s_axi4s.tready = aresetn && s_ready;

  // An admitted SOF beat is handled exactly like a PASS beat, using the
  // parameters being latched on that same cycle.
  always_comb begin
    s_sof      = s_axi4s.tuser[SOF_BIT];
    s_hs       = s_axi4s.tvalid && s_ready;
    admit      = (state == ST_WAIT_SOF) && s_hs && ctl_enable && s_sof && (skip_cnt == '0);
    in_frame   = admit || ((state == ST_PASS) && s_hs);
    height_cur = admit ? param_height : height_l;
    blank_cur  = admit ? param_blank_num : blank_l;
    y_base     = s_sof ? '0 : y_cnt;
    frame_end  = in_frame && s_axi4s.tlast && (y_base == height_cur - Y_ONE);
    bg_start   = frame_end && (blank_cur != '0);
    bg_ready   = (state == ST_FLUSH) && out_load;
  end

  video_dnn_blank_generator #(
    .IMG_X_WIDTH   (IMG_X_WIDTH),
    .BLANK_Y_WIDTH (BLANK_Y_WIDTH)
  ) u_blank_gen (
    .aresetn    (aresetn),
    .aclk       (aclk),
    .start      (bg_start),
    .width      (width_l),
    .lines      (blank_l),
    .beat_valid (bg_valid),
    .beat_last  (bg_last),
    .beat_ready (bg_ready),
    .done       (bg_done)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state              <= ST_IDLE;
      skip_cnt           <= '0;
      y_cnt              <= '0;
      width_l            <= '0;
      height_l           <= '0;
      blank_l            <= '0;
      status_frame_count <= '0;
      status_error_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctl_enable) state <= ST_WAIT_SOF;
        end
        ST_WAIT_SOF: begin
          if (s_hs) begin
            if (!ctl_enable) begin
              state <= ST_IDLE;
            end else if (s_sof && (skip_cnt != '0)) begin
              skip_cnt <= skip_cnt - S_ONE;
            end
          end
        end
        ST_FLUSH: begin
          if (bg_done) state <= ctl_enable ? ST_WAIT_SOF : ST_IDLE;
        end
        default: ;
      endcase

      if (admit) begin
        width_l  <= param_width;
        height_l <= param_height;
        blank_l  <= param_blank_num;
        skip_cnt <= param_skip;
        state    <= ST_PASS;
      end

      if (in_frame) begin
        if ((state == ST_PASS) && s_sof) begin
          status_error_count <= sat_inc(status_error_count);
        end
        if (frame_end) begin
          y_cnt              <= '0;
          status_frame_count <= status_frame_count + CNT_ONE;
          if (blank_cur != '0)  state <= ST_FLUSH;
          else if (ctl_enable)  state <= ST_WAIT_SOF;
          else                  state <= ST_IDLE;
        end else if (s_axi4s.tlast) begin
          y_cnt <= y_base + Y_ONE;
        end else begin
          y_cnt <= y_base;
        end
      end
    end
  end

  // Output register stage (p1): forwarded pixel or flush beat
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_tuser_p1  <= '0;
      out_tlast_p1  <= 1'b0;
      out_tdata_p1  <= '0;
      out_tvalid_p1 <= 1'b0;
    end else if (out_load) begin
      if (in_frame) begin
        out_tuser_p1  <= s_axi4s.tuser;
        out_tlast_p1  <= s_axi4s.tlast;
        out_tdata_p1  <= s_axi4s.tdata;
        out_tvalid_p1 <= 1'b1;
      end else if (bg_valid && bg_ready) begin
        out_tuser_p1  <= '0;
        out_tlast_p1  <= bg_last;
        out_tdata_p1  <= '0;
        out_tvalid_p1 <= 1'b1;
      end else begin
        out_tvalid_p1 <= 1'b0;
      end
    end
  end

  assign m_axi4s.tuser  = out_tuser_p1;
  assign m_axi4s.tlast  = out_tlast_p1;
  assign m_axi4s.tdata  = out_tdata_p1;
  assign m_axi4s.tvalid = out_tvalid_p1;

  assign status_busy = (state == ST_PASS) || (state == ST_FLUSH);

endmodule
